// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: MEM-stage instruction fields, data-memory response, stall and register-file write port.
// Pure wiring; the stage registers the write port and decides stall_req combinationally.
// master = upstream/memory/regfile side, slave = the mem_wb_stage itself.
interface mem_wb_stage_if;
    logic        flush;
    logic        mem_valid;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        stall_req;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_err;

    modport master (
        output flush, mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_is_load,
               mem_load_type, mem_addr_lo, dm_rdata, dm_rvalid,
        input  stall_req, wb_we, wb_waddr, wb_wdata, wb_err
    );

    modport slave (
        input  flush, mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_is_load,
               mem_load_type, mem_addr_lo, dm_rdata, dm_rvalid,
        output stall_req, wb_we, wb_waddr, wb_wdata, wb_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Write-back stage: registers MEM results, waits for late load data, extracts/extends bytes and halves.
// Latency 1 cycle from accepted instruction (or from dm_rvalid for a late load) to wb_we/wb_err.
// stall_req is raised while a legal load has no data; flush drops everything and clears the stall.
// Ports: cpu_clk_75M, cpu_rst_n (async active-low), bus (mem_wb_stage_if.slave: mem_*/dm_* in, stall_req/wb_* out).
module mem_wb_stage #(
    parameter int LOAD_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic          cpu_clk_75M,
    input  logic          cpu_rst_n,
    mem_wb_stage_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    // Fields of the outstanding load, captured when it enters WAIT
    logic       lat_wreg;
    logic [4:0] lat_waddr;
    logic [2:0] lat_type;
    logic [1:0] lat_lo;

    function automatic logic load_illegal(input logic [2:0] t, input logic [1:0] lo);
        return (t > 3'b100) ||
               ((t[2:1] == 2'b01) && lo[0]) ||
               ((t == 3'b100) && (lo != 2'b00));
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] t, input logic [1:0] lo,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {lo, 3'b000});
        h = 16'(d >> {lo[1], 4'b0000});
        case (t)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {24'h0, b};
            3'b010:  return {{16{h[15]}}, h};
            3'b011:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    logic        in_wait;
    logic        idle_take;
    logic        new_load;
    logic        new_bad;
    logic        new_good;
    logic        wait_hit;
    logic        timeout;
    logic        sel_wreg;
    logic [4:0]  sel_waddr;
    logic [2:0]  sel_type;
    logic [1:0]  sel_lo;
    logic [31:0] ld_data;
    logic        wr_ev;
    logic        wr_wreg;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_fire;

    always_comb begin
        in_wait   = (state == S_WAIT);
        idle_take = !in_wait && bus.mem_valid && !bus.flush;
        new_load  = idle_take && bus.mem_is_load;
        new_bad   = new_load && load_illegal(bus.mem_load_type, bus.mem_addr_lo);
        new_good  = new_load && !new_bad;
        wait_hit  = in_wait && bus.dm_rvalid && !bus.flush;
        // Counter counts WAIT cycles already spent; the LOAD_TIMEOUT-th empty one gives up
        timeout   = in_wait && !bus.dm_rvalid && (cnt == CNT_W'(LOAD_TIMEOUT - 1));

        // In WAIT the mem_* bus may carry anything, so use the captured fields
        sel_wreg  = in_wait ? lat_wreg  : bus.mem_wreg;
        sel_waddr = in_wait ? lat_waddr : bus.mem_waddr;
        sel_type  = in_wait ? lat_type  : bus.mem_load_type;
        sel_lo    = in_wait ? lat_lo    : bus.mem_addr_lo;
        ld_data   = load_extract(sel_type, sel_lo, bus.dm_rdata);

        wr_ev   = 1'b0;
        wr_wreg = 1'b0;
        wr_addr = sel_waddr;
        wr_data = ld_data;
        if (idle_take && !bus.mem_is_load) begin
            wr_ev   = 1'b1;
            wr_wreg = bus.mem_wreg;
            wr_data = bus.mem_wdata;
        end else if ((new_good && bus.dm_rvalid) || wait_hit) begin
            wr_ev   = 1'b1;
            wr_wreg = sel_wreg;
        end
        wr_fire = wr_ev && wr_wreg && (wr_addr != 5'd0);
    end

    // Stall drops in the very cycle data arrives so upstream can advance alongside the write
    assign bus.stall_req = !bus.flush && !bus.dm_rvalid && (new_good || in_wait);

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_wreg     <= 1'b0;
            lat_waddr    <= 5'd0;
            lat_type     <= 3'd0;
            lat_lo       <= 2'd0;
            bus.wb_we    <= 1'b0;
            bus.wb_waddr <= 5'd0;
            bus.wb_wdata <= 32'd0;
            bus.wb_err   <= 1'b0;
        end else begin
            bus.wb_we  <= 1'b0;
            bus.wb_err <= 1'b0;
            if (wr_fire) begin
                bus.wb_we    <= 1'b1;
                bus.wb_waddr <= wr_addr;
                bus.wb_wdata <= wr_data;
            end
            if (bus.flush) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else if (!in_wait) begin
                if (new_bad) begin
                    bus.wb_err <= 1'b1;
                end else if (new_good && !bus.dm_rvalid) begin
                    state     <= S_WAIT;
                    cnt       <= '0;
                    lat_wreg  <= bus.mem_wreg;
                    lat_waddr <= bus.mem_waddr;
                    lat_type  <= bus.mem_load_type;
                    lat_lo    <= bus.mem_addr_lo;
                end
            end else begin
                if (bus.dm_rvalid) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end else if (timeout) begin
                    bus.wb_err <= 1'b1;
                    state      <= S_IDLE;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, non-loads, load extraction, late load, errors, timeout, flush.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// DUT built with LOAD_TIMEOUT=4 so the timeout path is reachable in a few cycles.
module tb_mem_wb_stage;

    logic cpu_clk_75M = 1'b0;
    logic cpu_rst_n   = 1'b0;
    int   checks      = 0;
    int   errors      = 0;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(8)) dut (
        .cpu_clk_75M (cpu_clk_75M),
        .cpu_rst_n   (cpu_rst_n),
        .bus         (bus)
    );

    always #5 cpu_clk_75M = ~cpu_clk_75M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge cpu_clk_75M);
        #1;
    endtask

    task automatic idle_in();
        bus.flush       = 1'b0;
        bus.mem_valid   = 1'b0;
        bus.mem_wreg    = 1'b0;
        bus.mem_waddr   = 5'd0;
        bus.mem_wdata   = 32'd0;
        bus.mem_is_load = 1'b0;
        bus.mem_load_type = 3'd0;
        bus.mem_addr_lo = 2'd0;
        bus.dm_rdata    = 32'd0;
        bus.dm_rvalid   = 1'b0;
    endtask

    task automatic load(input logic [4:0] a, input logic [2:0] t, input logic [1:0] lo,
                        input logic rv, input logic [31:0] d);
        bus.mem_valid     = 1'b1;
        bus.mem_is_load   = 1'b1;
        bus.mem_wreg      = 1'b1;
        bus.mem_waddr     = a;
        bus.mem_load_type = t;
        bus.mem_addr_lo   = lo;
        bus.dm_rvalid     = rv;
        bus.dm_rdata      = d;
    endtask

    // Same-cycle load with data present: no stall, write of the extracted value next cycle
    task automatic imm_load(input string tag, input logic [2:0] t, input logic [1:0] lo,
                            input logic [31:0] exp);
        load(5'd3, t, lo, 1'b1, 32'h80FF7F01);
        #1;
        chk({tag, "_stall"}, bus.stall_req, 1'b0);
        cyc();
        idle_in();
        chk({tag, "_we"}, bus.wb_we, 1'b1);
        chk({tag, "_data"}, bus.wb_wdata, exp);
    endtask

    initial begin
        idle_in();
        #12;
        chk("rst_we", bus.wb_we, 1'b0);
        chk("rst_waddr", bus.wb_waddr, 5'd0);
        chk("rst_wdata", bus.wb_wdata, 32'd0);
        chk("rst_err", bus.wb_err, 1'b0);
        chk("rst_stall", bus.stall_req, 1'b0);
        #1 cpu_rst_n = 1'b1;
        cyc();

        // Non-load pair: second has destination 0 so no write, address/data hold
        bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1;
        bus.mem_waddr = 5'd5; bus.mem_wdata = 32'h12345678;
        #1 chk("nl_stall", bus.stall_req, 1'b0);
        cyc();
        bus.mem_waddr = 5'd0; bus.mem_wdata = 32'hFFFFFFFF;
        chk("nl0_we", bus.wb_we, 1'b1);
        chk("nl0_addr", bus.wb_waddr, 5'd5);
        chk("nl0_data", bus.wb_wdata, 32'h12345678);
        cyc();
        bus.mem_waddr = 5'd7; bus.mem_wreg = 1'b0; bus.mem_wdata = 32'h0000AAAA;
        chk("nl1_we", bus.wb_we, 1'b0);
        chk("nl1_addr_hold", bus.wb_waddr, 5'd5);
        chk("nl1_data_hold", bus.wb_wdata, 32'h12345678);
        cyc();
        idle_in();
        chk("nl_nowreg_we", bus.wb_we, 1'b0);

        // Immediate loads from 0x80FF7F01
        imm_load("lb3",  3'b000, 2'd3, 32'hFFFFFF80);
        imm_load("lbu3", 3'b001, 2'd3, 32'h00000080);
        imm_load("lb1",  3'b000, 2'd1, 32'h0000007F);
        imm_load("lh2",  3'b010, 2'd2, 32'hFFFF80FF);
        imm_load("lh0",  3'b010, 2'd0, 32'h00007F01);
        imm_load("lhu0", 3'b011, 2'd0, 32'h00007F01);
        imm_load("lhu2", 3'b011, 2'd2, 32'h000080FF);
        imm_load("lw0",  3'b100, 2'd0, 32'h80FF7F01);
        chk("imm_addr", bus.wb_waddr, 5'd3);

        // Late LW to r9: mem_* scrambled during WAIT must not matter
        load(5'd9, 3'b100, 2'd0, 1'b0, 32'h0);
        #1 chk("late_stall0", bus.stall_req, 1'b1);
        cyc();
        load(5'd4, 3'b000, 2'd3, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("late_stall%0d", i + 1), bus.stall_req, 1'b1);
            chk($sformatf("late_we%0d", i + 1), bus.wb_we, 1'b0);
            cyc();
        end
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'hCAFEBABE;
        #1 chk("late_stall_drop", bus.stall_req, 1'b0);
        cyc();
        idle_in();
        chk("late_we", bus.wb_we, 1'b1);
        chk("late_addr", bus.wb_waddr, 5'd9);
        chk("late_data", bus.wb_wdata, 32'hCAFEBABE);
        chk("late_stall_after", bus.stall_req, 1'b0);

        // Illegal loads: error pulse next cycle, never a stall or write
        load(5'd2, 3'b100, 2'd2, 1'b0, 32'h0);
        #1 chk("mis_lw_stall", bus.stall_req, 1'b0);
        cyc();
        load(5'd2, 3'b010, 2'd1, 1'b1, 32'h11111111);
        chk("mis_lw_err", bus.wb_err, 1'b1);
        chk("mis_lw_we", bus.wb_we, 1'b0);
        cyc();
        load(5'd2, 3'b101, 2'd0, 1'b1, 32'h11111111);
        chk("mis_lh_err", bus.wb_err, 1'b1);
        chk("mis_lh_we", bus.wb_we, 1'b0);
        cyc();
        idle_in();
        chk("bad_type_err", bus.wb_err, 1'b1);
        chk("bad_type_we", bus.wb_we, 1'b0);
        cyc();
        chk("err_pulse_end", bus.wb_err, 1'b0);

        // Timeout: 4 empty WAIT cycles then error, no write
        load(5'd6, 3'b001, 2'd0, 1'b0, 32'h0);
        #1 chk("to_stall_issue", bus.stall_req, 1'b1);
        cyc();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stall_w%0d", i), bus.stall_req, 1'b1);
            chk($sformatf("to_err_w%0d", i), bus.wb_err, 1'b0);
            cyc();
        end
        chk("to_err", bus.wb_err, 1'b1);
        chk("to_we", bus.wb_we, 1'b0);
        chk("to_stall_idle", bus.stall_req, 1'b0);
        cyc();
        chk("to_err_end", bus.wb_err, 1'b0);

        // Flush in WAIT coincident with dm_rvalid
        load(5'd10, 3'b100, 2'd0, 1'b0, 32'h0);
        cyc();
        idle_in();
        bus.flush = 1'b1; bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'hDEADBEEF;
        #1 chk("fl_stall", bus.stall_req, 1'b0);
        cyc();
        idle_in();
        chk("fl_we", bus.wb_we, 1'b0);
        chk("fl_err", bus.wb_err, 1'b0);
        chk("fl_stall_after", bus.stall_req, 1'b0);
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'h0BADF00D;
        cyc();
        idle_in();
        chk("fl_late_rvalid_we", bus.wb_we, 1'b0);
        bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1;
        bus.mem_waddr = 5'd11; bus.mem_wdata = 32'h00000055;
        cyc();
        idle_in();
        chk("fl_next_we", bus.wb_we, 1'b1);
        chk("fl_next_addr", bus.wb_waddr, 5'd11);
        chk("fl_next_data", bus.wb_wdata, 32'h00000055);

        // Flush overrides an instruction presented in IDLE
        bus.flush = 1'b1; bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1;
        bus.mem_waddr = 5'd12; bus.mem_wdata = 32'h77777777;
        cyc();
        idle_in();
        chk("fl_idle_we", bus.wb_we, 1'b0);
        chk("fl_idle_addr_hold", bus.wb_waddr, 5'd11);

        // Asynchronous reset while waiting
        load(5'd13, 3'b100, 2'd0, 1'b0, 32'h0);
        cyc();
        idle_in();
        #1 chk("rw_stall_pre", bus.stall_req, 1'b1);
        cpu_rst_n = 1'b0;
        #1;
        chk("rw_we", bus.wb_we, 1'b0);
        chk("rw_waddr", bus.wb_waddr, 5'd0);
        chk("rw_wdata", bus.wb_wdata, 32'd0);
        chk("rw_err", bus.wb_err, 1'b0);
        chk("rw_stall", bus.stall_req, 1'b0);
        cpu_rst_n = 1'b1;
        cyc();
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'h00001234;
        cyc();
        idle_in();
        chk("rw_post_we", bus.wb_we, 1'b0);
        chk("rw_post_stall", bus.stall_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Backstop so the run always ends even if the sequence above stalls
    initial begin
        #20000;
        $display("FAIL timeout observed sequence_incomplete expected sequence_done");
        $fatal(1, "bench time limit");
    end

endmodule
